// File: rtl/cube_net_driver_if.sv
// ---------------------------------------------------------------------------
// | Module   : cube_net_driver_if                                            |
// | Brief    : Host byte stream, network load/result and host result bundle  |
// |            for the cube classifier network driver.                      |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface cube_net_driver_if #(
  parameter int D_WIDTH = 128,
  parameter int BYTE_W  = 8,
  parameter int Q_WIDTH = 4
) ();

  // Host byte stream
  logic               in_valid;
  logic               in_ready;
  logic [BYTE_W-1:0]  in_data;

  // Network side
  logic               net_load;
  logic [D_WIDTH-1:0] net_d;
  logic               net_valid;
  logic [Q_WIDTH-1:0] net_q;

  // Result back to the host
  logic               res_valid;
  logic               res_ready;
  logic [Q_WIDTH-1:0] res_data;
  logic               res_err;

  // Driver view
  modport master (
    input  in_valid, in_data, net_valid, net_q, res_ready,
    output in_ready, net_load, net_d, res_valid, res_data, res_err
  );

  // Host / network view
  modport slave (
    output in_valid, in_data, net_valid, net_q, res_ready,
    input  in_ready, net_load, net_d, res_valid, res_data, res_err
  );

endinterface

`default_nettype wire

// File: rtl/cube_net_driver.sv
// ---------------------------------------------------------------------------
// | Module   : cube_net_driver                                               |
// | Brief    : Collects a D_WIDTH cube-state vector from a byte stream,      |
// |            runs the classifier network and returns its class to the     |
// |            host. Optional watchdog: CUBE_NET_DRIVER_TIMEOUT_EN.          |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module cube_net_driver #(
  parameter int D_WIDTH = 128,
  parameter int BYTE_W  = 8,
  parameter int Q_WIDTH = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cube_net_driver_if.master    bus,
  output logic                 busy
);

  localparam int c_BEATS = D_WIDTH / BYTE_W;
  localparam int c_CNT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);

  localparam logic [2:0] c_ST_COLLECT = 3'd0;
  localparam logic [2:0] c_ST_LOAD    = 3'd1;
  localparam logic [2:0] c_ST_WAIT    = 3'd2;
  localparam logic [2:0] c_ST_RESULT  = 3'd3;
  localparam logic [2:0] c_ST_DRAIN   = 3'd4;

  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_count;
  logic [D_WIDTH-1:0] r_net_d;
  logic               r_net_load;
  logic               r_in_ready;
  logic               r_res_valid;
  logic [Q_WIDTH-1:0] r_res_data;
  logic               r_res_err;
  logic               r_busy;
  logic               w_timeout;

`ifdef CUBE_NET_DRIVER_TIMEOUT_EN
  localparam int c_WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

  logic [c_WD_W-1:0] r_wd;

  // Watchdog: zeroed while loading so the first WAIT cycle reads 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd <= '0;
    end else if (r_state == c_ST_LOAD) begin
      r_wd <= '0;
    end else if (r_state == c_ST_WAIT) begin
      r_wd <= r_wd + c_WD_W'(1);
    end
  end

  assign w_timeout = (r_wd == c_WD_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout        = 1'b0;
`endif

  // Main sequencer; every host/network output is a flop updated here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_COLLECT;
      r_count     <= '0;
      r_net_d     <= '0;
      r_net_load  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        c_ST_COLLECT: begin
          if (bus.in_valid && r_in_ready) begin
            // First byte ends up as the most significant byte
            r_net_d <= {r_net_d[D_WIDTH-BYTE_W-1:0], bus.in_data};
            if (r_count == c_LAST_BEAT) begin
              r_count    <= '0;
              r_state    <= c_ST_LOAD;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_count <= r_count + c_CNT_W'(1);
            end
          end
        end

        c_ST_LOAD: begin
          // net_valid is deliberately not looked at in this cycle
          r_net_load <= 1'b1;
          r_state    <= c_ST_WAIT;
        end

        c_ST_WAIT: begin
          if (bus.net_valid) begin
            r_res_data  <= bus.net_q;
            r_res_err   <= 1'b0;
            r_net_load  <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= c_ST_RESULT;
          end else if (w_timeout) begin
            r_res_data  <= {Q_WIDTH{1'b1}};
            r_res_err   <= 1'b1;
            r_net_load  <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= c_ST_RESULT;
          end
        end

        c_ST_RESULT: begin
          if (r_res_valid && bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= c_ST_DRAIN;
          end
        end

        c_ST_DRAIN: begin
          // A still-high net_valid must not complete the next query
          if (!bus.net_valid) begin
            r_state    <= c_ST_COLLECT;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end

        default: begin
          r_state     <= c_ST_COLLECT;
          r_count     <= '0;
          r_net_load  <= 1'b0;
          r_in_ready  <= 1'b1;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.net_load  = r_net_load;
  assign bus.net_d     = r_net_d;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_err   = r_res_err;
  assign busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_cube_net_driver.sv
// ---------------------------------------------------------------------------
// | Module   : tb_cube_net_driver                                            |
// | Brief    : Directed, table-driven bench for cube_net_driver.             |
// |            Watchdog sequence enabled by CUBE_NET_DRIVER_TIMEOUT_EN.      |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_cube_net_driver;

  localparam int D_WIDTH = 128;
  localparam int BYTE_W  = 8;
  localparam int Q_WIDTH = 4;
  localparam int TIMEOUT = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  cube_net_driver_if #(.D_WIDTH(D_WIDTH), .BYTE_W(BYTE_W), .Q_WIDTH(Q_WIDTH)) bus ();

  cube_net_driver #(
    .D_WIDTH(D_WIDTH), .BYTE_W(BYTE_W), .Q_WIDTH(Q_WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    bit           gapped;
    logic [3:0]   q;
    int           wait_cyc;
    int           rr_delay;    // 0: res_ready already high on RESULT entry
    bit           hold_valid;  // keep net_valid high after the result
    logic [127:0] exp_d;
    logic [3:0]   exp_q;
  } query_t;

  query_t tbl [4];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 50) begin
      step();
      t++;
    end
    if (!bus.in_ready) chk("in_ready_wait", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [127:0] d, input int n, input bit gapped);
    for (int i = 0; i < n; i++) begin
      send_byte(d[127-8*i -: 8]);
      if (gapped && i < n - 1) step();
    end
  endtask

  task automatic finish_result();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    step();
    chk("back_to_collect", bus.in_ready, 1'b1);
  endtask

  task automatic run_query(input query_t v);
    send_bytes(v.d, 16, v.gapped);
    chk("load_in_ready", bus.in_ready, 1'b0);
    chk("load_net_load", bus.net_load, 1'b0);
    chk("load_busy", busy, 1'b1);
    step();
    chk("net_load_high", bus.net_load, 1'b1);
    chk("net_d", bus.net_d, v.exp_d);
    repeat (v.wait_cyc) step();
    chk("net_load_held", bus.net_load, 1'b1);
    chk("res_valid_early", bus.res_valid, 1'b0);
    if (v.rr_delay == 0) bus.res_ready = 1'b1;
    bus.net_valid = 1'b1;
    bus.net_q     = v.q;
    step();
    chk("res_valid", bus.res_valid, 1'b1);
    chk("res_data", bus.res_data, v.exp_q);
    chk("res_err", bus.res_err, 1'b0);
    chk("net_load_drop", bus.net_load, 1'b0);
    bus.net_q = ~v.q;
    if (!v.hold_valid) bus.net_valid = 1'b0;
    if (v.rr_delay == 0) begin
      step();
      chk("res_valid_pulse", bus.res_valid, 1'b0);
      bus.res_ready = 1'b0;
    end else begin
      repeat (v.rr_delay) step();
      chk("res_valid_held", bus.res_valid, 1'b1);
      chk("res_data_stable", bus.res_data, v.exp_q);
      bus.res_ready = 1'b1;
      step();
      chk("res_valid_clear", bus.res_valid, 1'b0);
      bus.res_ready = 1'b0;
    end
    if (v.hold_valid) begin
      repeat (3) step();
      chk("drain_in_ready", bus.in_ready, 1'b0);
      chk("drain_busy", busy, 1'b1);
      bus.net_valid = 1'b0;
      step();
    end else begin
      step();
    end
    chk("idle_in_ready", bus.in_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    tbl[0] = '{128'h0000082a54907b1630900184e800098f, 1'b0, 4'b0110, 300, 20, 1'b0,
               128'h0000082a54907b1630900184e800098f, 4'b0110};
    tbl[1] = '{128'h0000082a54907b1630900184e800098f, 1'b1, 4'h9, 3, 0, 1'b1,
               128'h0000082a54907b1630900184e800098f, 4'h9};
    tbl[2] = '{128'hffeeddccbbaa99887766554433221100, 1'b0, 4'hf, 0, 1, 1'b0,
               128'hffeeddccbbaa99887766554433221100, 4'hf};
    tbl[3] = '{128'h0123456789abcdef0011223344556677, 1'b1, 4'h0, 5, 2, 1'b0,
               128'h0123456789abcdef0011223344556677, 4'h0};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.net_valid = 1'b0;
    bus.net_q     = '0;
    bus.res_ready = 1'b0;

    // Reset defaults
    repeat (3) step();
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_net_load", bus.net_load, 1'b0);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_net_d", bus.net_d, 128'h0);
    chk("rst_res_data", bus.res_data, 4'h0);
    chk("rst_res_err", bus.res_err, 1'b0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) run_query(tbl[i]);

    // net_valid during LOAD must be ignored
    send_bytes(tbl[3].d, 16, 1'b0);
    bus.net_valid = 1'b1;
    bus.net_q     = 4'h3;
    step();
    bus.net_valid = 1'b0;
    repeat (3) step();
    chk("load_valid_ignored", bus.res_valid, 1'b0);
    chk("load_valid_net_load", bus.net_load, 1'b1);
    bus.net_valid = 1'b1;
    bus.net_q     = 4'h5;
    step();
    bus.net_valid = 1'b0;
    chk("post_load_res_valid", bus.res_valid, 1'b1);
    chk("post_load_res_data", bus.res_data, 4'h5);
    finish_result();

    // Asynchronous reset while WAIT is holding net_load
    send_bytes(tbl[2].d, 16, 1'b0);
    step();
    chk("pre_rst_net_load", bus.net_load, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_net_load", bus.net_load, 1'b0);
    chk("async_rst_in_ready", bus.in_ready, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // Reset after a partial vector, then a fresh full query
    send_bytes(tbl[0].d, 7, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("partial_rst_net_d", bus.net_d, 128'h0);
    step();
    rst_n = 1'b1;
    step();
    run_query(tbl[2]);

`ifdef CUBE_NET_DRIVER_TIMEOUT_EN
    begin
      int n = 0;
      send_bytes(tbl[0].d, 16, 1'b0);
      step();
      while (!bus.res_valid && n < 200) begin
        step();
        n++;
      end
      chk("timeout_cycles", n, 64);
      chk("timeout_res_err", bus.res_err, 1'b1);
      chk("timeout_res_data", bus.res_data, 4'hf);
      chk("timeout_net_load", bus.net_load, 1'b0);
      finish_result();
    end
`else
    // No watchdog: WAIT stays put indefinitely
    send_bytes(tbl[0].d, 16, 1'b0);
    step();
    repeat (200) step();
    chk("nowd_res_valid", bus.res_valid, 1'b0);
    chk("nowd_net_load", bus.net_load, 1'b1);
    bus.net_valid = 1'b1;
    bus.net_q     = 4'ha;
    step();
    bus.net_valid = 1'b0;
    chk("nowd_res_data", bus.res_data, 4'ha);
    chk("nowd_res_err", bus.res_err, 1'b0);
    finish_result();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cube_net_driver.md
Name: cube_net_driver

Overview:
Initiator-side controller for the cube classifier network. Accepts a byte stream from the host over a valid/ready handshake and assembles the 128-bit cube-state vector. It then drives the network's load/d inputs, waits for the network's valid, captures the 4-bit class q, and returns it to the host over a second valid/ready handshake. It sits between the host interface and the network instance.

Parameters:
D_WIDTH, 128, width of the network input vector; must be a multiple of BYTE_W.
BYTE_W, 8, width of one host input beat.
Q_WIDTH, 4, width of the network result.
TIMEOUT, 4096, watchdog limit in cycles; used only with TIMEOUT_EN.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  host byte valid.
in_ready  output  1  driver can accept a byte.
in_data  input  BYTE_W  host byte; first byte is the MS byte of net_d.
net_load  output  1  load/run request to the network.
net_d  output  D_WIDTH  cube-state vector to the network.
net_valid  input  1  network result valid.
net_q  input  Q_WIDTH  network result.
res_valid  output  1  result available to the host.
res_ready  input  1  host accepts the result.
res_data  output  Q_WIDTH  captured class.
res_err  output  1  result invalid (timeout); tied 0 without TIMEOUT_EN.
busy  output  1  high in any state other than COLLECT.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=COLLECT; byte counter=0; net_d=0; net_load=0.
  - res_valid=0; res_data=0; res_err=0; busy=0; in_ready=1.
- COLLECT:
  - in_ready=1.
  - Each cycle with in_valid&in_ready: net_d <= {net_d[D_WIDTH-BYTE_W-1:0], in_data}, and count increments.
  - On the D_WIDTH/BYTE_W-th accepted byte (16 by default), count wraps to 0 and the next state is LOAD.
  - in_valid low inserts bubbles, with no effect on the state.
- LOAD (1 cycle):
  - in_ready=0; net_load <= 1.
  - net_d is frozen from here until the next COLLECT.
  - Next state is WAIT.
- WAIT:
  - net_load is held at 1 (level, not pulse).
  - net_valid is honoured only from the first WAIT cycle onward. net_valid high during LOAD is ignored.
  - On net_valid=1: res_data <= net_q; res_err <= 0; net_load <= 0; next state is RESULT.
- RESULT:
  - res_valid=1; res_data and res_err are held stable until res_ready=1.
  - On res_valid&res_ready: res_valid <= 0; next state is DRAIN.
- DRAIN:
  - Waits for net_valid=0, then goes to COLLECT.
  - This prevents a stale valid from completing the next query.
  - Zero-length if net_valid is already low.
- Latency:
  - Last byte accepted to net_load high: 1 cycle.
  - net_valid high to res_valid high: 1 cycle.
  - res_ready to in_ready high: at least 2 cycles.
- Boundary conditions:
  - Bytes offered while in_ready=0 are not consumed; the host must hold them.
  - Reset mid-query drops net_load immediately and discards any partial vector.
  - If res_ready is already high on RESULT entry, res_valid is high for exactly 1 cycle.
  - net_q changes after capture have no effect on res_data.
  - All outputs are registered.

Optional Feature:
- Macro: CUBE_NET_DRIVER_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counter clears on LOAD entry and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 with no net_valid: net_load <= 0; res_data <= {Q_WIDTH{1'b1}}; res_err <= 1; next state is RESULT.
  - net_valid on the same cycle as the timeout wins, giving a normal result.
- Without the macro: WAIT has no bound, res_err is constant 0, and no counter is synthesised.

Test Plan:
- Reset, then check defaults: in_ready=1, net_load=0, res_valid=0, busy=0, net_d=0.
- Stream bytes 00 00 08 2a 54 90 7b 16 30 90 01 84 e8 00 09 8f back-to-back -> net_d=128'h0000082a54907b1630900184e800098f, with net_load high 1 cycle after the last byte and in_ready=0.
- Same query, with the model asserting net_valid and net_q=4'b0110 after 300 cycles -> res_valid 1 cycle later, res_data=4'b0110, net_load=0; res_ready held low 20 cycles -> res_data stable; after res_ready -> back to COLLECT once net_valid drops.
- Gapped input (in_valid toggling 1,0,1,0...) plus a held net_valid after the result -> same net_d assembly; second query does not complete until net_valid falls and rises again.
- Assert rst_n=0 after 7 bytes, then release -> net_load=0, count=0; the next 16 bytes form a fresh vector.
- TIMEOUT_EN with TIMEOUT=64 and net_valid never asserted -> res_valid at cycle 64 of WAIT, res_err=1, res_data=4'hF, net_load=0.
